// File: rtl/gf2_reduce_93bit_seq.sv
// Sequential reduction of a 185-bit carry-less product modulo x^93 + POLY_LOW, DIGIT bits per cycle.
// Optional macro GF2_REDUCE_EARLY_EXIT_EN finishes as soon as the high part of the accumulator is zero.
module gf2_reduce_93bit_seq #(
    parameter logic [92:0] POLY_LOW = 93'h5,
    parameter int          DIGIT    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [184:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [92:0]  out_data,
    output logic         busy
);

    localparam int N  = 92 / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]  LAST      = CW'(N - 1);
    localparam logic [184:0]   POLY_FULL = {91'd0, 1'b1, POLY_LOW};

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [184:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [184:0]   folded;

    // Bits above the current window are already zero, so any j >= lo can be folded in descending order.
    function automatic logic [184:0] foldStep(input logic [184:0] accIn, input logic [CW-1:0] cnt);
        logic [184:0] a;
        int           lo;
        a  = accIn;
        lo = 185 - (int'(cnt) + 1) * DIGIT;
        for (int j = 184; j >= 93; j--) begin
            if (j >= lo && a[j]) begin
                a = a ^ (POLY_FULL << (j - 93));
            end
        end
        return a;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        folded  = foldStep(acc_q, cnt_q);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d = in_data;
                    cnt_d = '0;
`ifdef GF2_REDUCE_EARLY_EXIT_EN
                    state_d = (in_data[184:93] == '0) ? DONE : REDUCE;
`else
                    state_d = REDUCE;
`endif
                end
            end
            REDUCE: begin
                acc_d = folded;
                cnt_d = cnt_q + 1'b1;
`ifdef GF2_REDUCE_EARLY_EXIT_EN
                if (cnt_q == LAST || folded[184:93] == '0) begin
                    state_d = DONE;
                end
`else
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = acc_q[92:0];

endmodule

// File: tb/tb_gf2_reduce_93bit_seq.sv
// Directed bench for gf2_reduce_93bit_seq: DIGIT=4 main instance plus DIGIT=1 and DIGIT=92 instances.
// Expected results come from an interleaved shift-and-reduce multiplier model.
module tb_gf2_reduce_93bit_seq;

    localparam logic [92:0] POLY_LOW = 93'h5;
`ifdef GF2_REDUCE_EARLY_EXIT_EN
    localparam int LOW_LAT = 1;
`else
    localparam int LOW_LAT = 24;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         xValid;
    logic         out_ready;
    logic [184:0] in_data;

    logic         in_ready, out_valid, busy;
    logic [92:0]  out_data;
    logic         d1InReady, d1OutValid, d1Busy;
    logic [92:0]  d1OutData;
    logic         d92InReady, d92OutValid, d92Busy;
    logic [92:0]  d92OutData;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gf2_reduce_93bit_seq #(.POLY_LOW(POLY_LOW), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    gf2_reduce_93bit_seq #(.POLY_LOW(POLY_LOW), .DIGIT(1)) dutD1 (
        .clk(clk), .rst(rst), .in_valid(xValid), .in_ready(d1InReady), .in_data(in_data),
        .out_valid(d1OutValid), .out_ready(out_ready), .out_data(d1OutData), .busy(d1Busy)
    );

    gf2_reduce_93bit_seq #(.POLY_LOW(POLY_LOW), .DIGIT(92)) dutD92 (
        .clk(clk), .rst(rst), .in_valid(xValid), .in_ready(d92InReady), .in_data(in_data),
        .out_valid(d92OutValid), .out_ready(out_ready), .out_data(d92OutData), .busy(d92Busy)
    );

    function automatic logic [184:0] clmul(input logic [92:0] a, input logic [92:0] b);
        logic [184:0] p;
        p = '0;
        for (int i = 0; i < 93; i++) begin
            if (b[i]) p = p ^ ({92'd0, a} << i);
        end
        return p;
    endfunction

    // Multiply in the field directly: multiply a by x with reduction each step.
    function automatic logic [92:0] modmul(input logic [92:0] a, input logic [92:0] b);
        logic [92:0] r;
        logic [92:0] aa;
        logic        msb;
        r  = '0;
        aa = a;
        for (int i = 0; i < 93; i++) begin
            if (b[i]) r = r ^ aa;
            msb = aa[92];
            aa  = {aa[91:0], 1'b0} ^ (msb ? POLY_LOW : 93'd0);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [184:0] obs, input logic [184:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic waitValid(output int n);
        n = 1;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("outValidSeen", 185'(out_valid), 185'(1'b1));
    endtask

    // Drive one product into the main instance from IDLE, return its result and latency.
    task automatic applyStimulus(input logic [184:0] data, output logic [92:0] res, output int lat);
        in_data  = data;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        waitValid(lat);
        res = out_data;
        @(negedge clk);
    endtask

    task automatic runExtras(input string tag, input logic [184:0] data, input logic [92:0] exp);
        logic        seen1, seen92;
        logic [92:0] r1, r92;
        seen1  = 1'b0;
        seen92 = 1'b0;
        r1     = '0;
        r92    = '0;
        in_data = data;
        xValid  = 1'b1;
        @(negedge clk);
        xValid  = 1'b0;
        for (int c = 0; c < 150 && !(seen1 && seen92); c++) begin
            if (d1OutValid && !seen1) begin
                seen1 = 1'b1;
                r1    = d1OutData;
            end
            if (d92OutValid && !seen92) begin
                seen92 = 1'b1;
                r92    = d92OutData;
            end
            @(negedge clk);
        end
        @(negedge clk);
        checkOutput({tag, "_d1Seen"}, 185'(seen1), 185'(1'b1));
        checkOutput({tag, "_d1Data"}, 185'(r1), 185'(exp));
        checkOutput({tag, "_d92Seen"}, 185'(seen92), 185'(1'b1));
        checkOutput({tag, "_d92Data"}, 185'(r92), 185'(exp));
    endtask

    initial begin
        logic [92:0]  a, b, res, resA, resB, expC, expD, expTop;
        logic [184:0] prodA, prodB, prodC, prodD;
        int           lat;

        expTop    = (93'd1 << 91) | 93'h5;
        rst       = 1'b1;
        in_valid  = 1'b0;
        xValid    = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstInReady", 185'(in_ready), 185'(1'b1));
        checkOutput("rstOutValid", 185'(out_valid), 185'(1'b0));
        checkOutput("rstOutData", 185'(out_data), 185'(0));
        checkOutput("rstBusy", 185'(busy), 185'(1'b0));
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(185'h1234, res, lat);
        checkOutput("lowData", 185'(res), 185'(93'h1234));
        checkOutput("lowLatency", 185'(lat), 185'(LOW_LAT));

        applyStimulus(185'd1 << 93, res, lat);
        checkOutput("x93Data", 185'(res), 185'(93'h5));
        checkOutput("x93Latency", 185'(lat), 185'(24));
        applyStimulus(185'd1 << 184, res, lat);
        checkOutput("x184Data", 185'(res), 185'(expTop));

        runExtras("x93", 185'd1 << 93, 93'h5);
        runExtras("x184", 185'd1 << 184, expTop);

        for (int i = 0; i < 200; i++) begin
            a = 93'({$urandom(), $urandom(), $urandom()});
            b = 93'({$urandom(), $urandom(), $urandom()});
            if (i == 0) begin
                a = '1;
                b = '1;
            end else if (i == 1) begin
                a = '1;
            end
            applyStimulus(clmul(a, b), res, lat);
            checkOutput("randomData", 185'(res), 185'(modmul(a, b)));
        end

        // Backpressure: result must hold while out_ready is low and a new product must wait.
        a     = 93'h1_2345_6789_abcd_ef01_2345;
        b     = 93'h1f_fedc_ba98_7654_3210_fedc;
        prodC = clmul(a, b);
        expC  = modmul(a, b);
        prodD = clmul(b, b);
        expD  = modmul(b, b);
        out_ready = 1'b0;
        in_data   = prodC;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        waitValid(lat);
        in_data  = prodD;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checkOutput("bpValid", 185'(out_valid), 185'(1'b1));
            checkOutput("bpData", 185'(out_data), 185'(expC));
            checkOutput("bpInReady", 185'(in_ready), 185'(1'b0));
            checkOutput("bpBusy", 185'(busy), 185'(1'b1));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bpRelValid", 185'(out_valid), 185'(1'b0));
        checkOutput("bpRelInReady", 185'(in_ready), 185'(1'b1));
        checkOutput("bpRelBusy", 185'(busy), 185'(1'b0));
        @(negedge clk);
        checkOutput("bpAcceptBusy", 185'(busy), 185'(1'b1));
        in_valid = 1'b0;
        waitValid(lat);
        checkOutput("bpNextData", 185'(out_data), 185'(expD));
        @(negedge clk);

        // Reset in the middle of a reduction.
        in_data  = 185'd1 << 184;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("midBusyBefore", 185'(busy), 185'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midOutValid", 185'(out_valid), 185'(1'b0));
        checkOutput("midInReady", 185'(in_ready), 185'(1'b1));
        checkOutput("midBusy", 185'(busy), 185'(1'b0));
        checkOutput("midOutData", 185'(out_data), 185'(0));
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(185'd1 << 93, res, lat);
        checkOutput("postRstData", 185'(res), 185'(93'h5));

        // Back-to-back with in_valid held high.
        prodA    = clmul(a, a);
        prodB    = clmul(93'h155, b);
        in_data  = prodA;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("b2bFirstTaken", 185'(in_ready), 185'(1'b0));
        in_data = prodB;
        waitValid(lat);
        resA = out_data;
        @(negedge clk);
        checkOutput("b2bIdleGap", 185'(in_ready), 185'(1'b1));
        @(negedge clk);
        checkOutput("b2bSecondTaken", 185'(busy), 185'(1'b1));
        in_valid = 1'b0;
        waitValid(lat);
        resB = out_data;
        @(negedge clk);
        checkOutput("b2bFirstData", 185'(resA), 185'(modmul(a, a)));
        checkOutput("b2bSecondData", 185'(resB), 185'(modmul(93'h155, b)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
